// File: rtl/seq_writeback.sv
// Y86-64 SEQ write-back stage: owns the architectural register bank, tracks
// retirement status and counts retired instructions.

module seq_wb_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_e,
  input  logic        we_m,
  input  logic [63:0] val_e,
  input  logic [63:0] val_m,
  output logic [63:0] q
);
  // M port has priority so popq %rsp lands the popped value
  always_ff @(posedge clk) begin
    if (!rst_n)    q <= '0;
    else if (we_m) q <= val_m;
    else if (we_e) q <= val_e;
  end
endmodule

module seq_writeback #(
  parameter int NREG   = 15,
  parameter int RSP_ID = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [3:0]           icode,
  input  logic [3:0]           rA,
  input  logic [3:0]           rB,
  input  logic                 cnd,
  input  logic [63:0]          valE,
  input  logic [63:0]          valM,
  input  logic [2:0]           stat_in,
  input  logic [3:0]           rd_addr,
  output logic [63:0]          rd_data,
  output logic [64*NREG-1:0]   reg_flat,
  output logic [3:0]           dstE,
  output logic [3:0]           dstM,
  output logic                 halted,
  output logic [2:0]           stat_out,
  output logic [CNT_W-1:0]     retired
);
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;
  localparam logic [2:0] AOK    = 3'd1;
  localparam logic [2:0] HLT    = 3'd2;
  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] RSP    = RSP_ID[3:0];
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]            state;
  logic [NREG-1:0][63:0] bank;
  logic                  run, wr_ok, retire;

  always_comb begin
    dstE = RNONE;
    unique case (icode)
      4'h2:                      dstE = cnd ? rB : RNONE;
      4'h3, 4'h6:                dstE = rB;
      4'h8, 4'h9, 4'hA, 4'hB:    dstE = RSP;
      default:                   dstE = RNONE;
    endcase
  end

  always_comb begin
    dstM = RNONE;
    if (icode == 4'h5 || icode == 4'hB) dstM = rA;
  end

  assign run    = (state == S_RUN);
  assign wr_ok  = run && valid && (stat_in == AOK);
  // a halting instruction still retires, faulting ones do not
  assign retire = run && valid && (stat_in == AOK || stat_in == HLT);

  // RNONE and out-of-range IDs never match a register index, so no write
  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_reg
      localparam logic [3:0] ID = g[3:0];
      seq_wb_reg u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we_e  (wr_ok && dstE == ID),
        .we_m  (wr_ok && dstM == ID),
        .val_e (valE),
        .val_m (valM),
        .q     (bank[g])
      );
    end
  endgenerate

  assign reg_flat = bank;
  assign rd_data  = (int'(rd_addr) < NREG) ? bank[rd_addr] : 64'd0;
  assign halted   = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_RUN;
      stat_out <= AOK;
      retired  <= '0;
    end else if (run && valid) begin
      if (retire) retired <= retired + ONE;
      if (stat_in != AOK) begin
        state    <= S_HALT;
        stat_out <= stat_in;
      end
    end
  end
endmodule
